// File: rtl/serial_bit_tx.sv
// serial_bit_tx -- parallel-in, serial-out bit transmitter.
//
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit per clock
// on the registered line d (with its complement dnot), followed by one gap cycle.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   in_data   word to transmit, captured on in_valid && in_ready
//   in_valid  upstream has a word
//   in_ready  block can accept a word this cycle (registered)
//   d         serial data bit (registered)
//   dnot      ~d, registered alongside d
//   d_valid   d carries a payload or parity bit
//   d_last    final bit of the frame
//   busy      a frame is in progress (state != idle)
//
// Optional build macro SERIAL_BIT_TX_PARITY_EN: append an even-parity bit (XOR of the
// payload) after the payload; d_last then marks the parity bit.

module serial_bit_tx #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             d,
    output logic             dnot,
    output logic             d_valid,
    output logic             d_last,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
`ifdef SERIAL_BIT_TX_PARITY_EN
    localparam int unsigned FrameBits = WIDTH + 1;
`else
    localparam int unsigned FrameBits = WIDTH;
`endif
    localparam logic [CntW-1:0] LastIdx    = CntW'(FrameBits - 1);
    localparam logic [CntW-1:0] PayloadEnd = CntW'(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             par_q, par_d;
    logic             d_q, d_d;
    logic             dnot_q, dnot_d;
    logic             d_valid_q, d_valid_d;
    logic             d_last_q, d_last_d;
    logic             in_ready_q, in_ready_d;
    logic             out_bit;

    // Bit currently at the output end of the shift register.
    assign out_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        par_d      = par_q;
        d_d        = 1'b0;
        d_valid_d  = 1'b0;
        d_last_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    shreg_d = in_data;
                    par_d   = ^in_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                d_valid_d = 1'b1;
                if (cnt_q < PayloadEnd) begin
                    d_d = out_bit;
                    if (MSB_FIRST) begin
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                end else begin
                    // Only reachable with the parity bit appended.
                    d_d = par_q;
                end
                if (cnt_q == LastIdx) begin
                    d_last_d = 1'b1;
                    state_d  = StGap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        dnot_d     = ~d_d;
        // Registered ready so it rises one cycle after reset release and lines up with
        // the state the next edge will leave us in.
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            cnt_q      <= '0;
            par_q      <= 1'b0;
            d_q        <= 1'b0;
            dnot_q     <= 1'b1;
            d_valid_q  <= 1'b0;
            d_last_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            par_q      <= par_d;
            d_q        <= d_d;
            dnot_q     <= dnot_d;
            d_valid_q  <= d_valid_d;
            d_last_q   <= d_last_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready = in_ready_q;
    assign d        = d_q;
    assign dnot     = dnot_q;
    assign d_valid  = d_valid_q;
    assign d_last   = d_last_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_serial_bit_tx.sv
module tb_serial_bit_tx;

`ifdef SERIAL_BIT_TX_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    typedef struct {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data0, in_data1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic       d0, d1, dnot0, dnot1, d_valid0, d_valid1, d_last0, d_last1, busy0, busy1;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];

    serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data0),
        .in_valid (in_valid0),
        .in_ready (in_ready0),
        .d        (d0),
        .dnot     (dnot0),
        .d_valid  (d_valid0),
        .d_last   (d_last0),
        .busy     (busy0)
    );

    serial_bit_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .d        (d1),
        .dnot     (dnot1),
        .d_valid  (d_valid1),
        .d_last   (d_last1),
        .busy     (busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected frame: bit i appears on d after edge hs+1+i.
    task automatic push_frame(input int which, input logic [7:0] data, input int hs);
        exp_t e;
        for (int i = 0; i < FB; i++) begin
            if (i < 8) e.b = (which == 0) ? data[7-i] : data[i];
            else       e.b = ^data;
            e.last = (i == FB - 1);
            e.cyc  = hs + 1 + i;
            if (which == 0) exp_q0.push_back(e);
            else            exp_q1.push_back(e);
        end
    endtask

    // Called at posedge+1; returns the cycle count of the handshake edge (or -1).
    task automatic send(input int which, input logic [7:0] data, input bit keep, output int hs);
        logic rdy;
        hs  = -1;
        rdy = 1'b0;
        if (which == 0) begin in_data0 = data; in_valid0 = 1'b1; end
        else            begin in_data1 = data; in_valid1 = 1'b1; end
        for (int k = 0; k < 60 && hs < 0; k++) begin
            rdy = (which == 0) ? in_ready0 : in_ready1;
            @(posedge clk);
            #1;
            if (rdy) hs = cyc;
        end
        if (hs < 0) begin
            chk("hs_timeout", {31'd0, rdy}, 32'd1);
        end else begin
            push_frame(which, data, hs);
            chk("busy_after_hs", {31'd0, (which == 0) ? busy0 : busy1}, 32'd1);
            chk("ready_after_hs", {31'd0, (which == 0) ? in_ready0 : in_ready1}, 32'd0);
        end
        if (!keep) begin
            if (which == 0) in_valid0 = 1'b0;
            else            in_valid1 = 1'b0;
        end
    endtask

    task automatic wait_to(input int target);
        for (int k = 0; k < 200 && cyc < target; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitors: pop one expected bit per valid cycle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (d_valid0) begin
                if (exp_q0.size() == 0) begin
                    chk("unexpected_valid0", {31'd0, d_valid0}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q0.pop_front();
                    chk("d0", {31'd0, d0}, {31'd0, e.b});
                    chk("dnot0", {31'd0, dnot0}, {31'd0, ~e.b});
                    chk("last0", {31'd0, d_last0}, {31'd0, e.last});
                    chk("bit_cyc0", cyc, e.cyc);
                end
            end else begin
                chk("idle_d0", {31'd0, d0}, 32'd0);
                chk("idle_dnot0", {31'd0, dnot0}, 32'd1);
                if (exp_q0.size() > 0 && exp_q0[0].cyc <= cyc)
                    chk("missing_bit0", {31'd0, d_valid0}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (d_valid1) begin
                if (exp_q1.size() == 0) begin
                    chk("unexpected_valid1", {31'd0, d_valid1}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q1.pop_front();
                    chk("d1", {31'd0, d1}, {31'd0, e.b});
                    chk("dnot1", {31'd0, dnot1}, {31'd0, ~e.b});
                    chk("last1", {31'd0, d_last1}, {31'd0, e.last});
                    chk("bit_cyc1", cyc, e.cyc);
                end
            end else begin
                chk("idle_d1", {31'd0, d1}, 32'd0);
                chk("idle_dnot1", {31'd0, dnot1}, 32'd1);
                if (exp_q1.size() > 0 && exp_q1[0].cyc <= cyc)
                    chk("missing_bit1", {31'd0, d_valid1}, 32'd1);
            end
        end
    end

    initial begin
        int hs, h1, h2;
        rst_n     = 1'b0;
        in_data0  = 8'hAA;
        in_valid0 = 1'b1;
        in_data1  = 8'h55;
        in_valid1 = 1'b1;

        // Reset held with in_valid high: nothing captured, outputs at reset values.
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_d", {31'd0, d0}, 32'd0);
            chk("rst_dnot", {31'd0, dnot0}, 32'd1);
            chk("rst_ready", {31'd0, in_ready0}, 32'd0);
            chk("rst_valid", {31'd0, d_valid0}, 32'd0);
            chk("rst_busy", {31'd0, busy0}, 32'd0);
            chk("rst_ready1", {31'd0, in_ready1}, 32'd0);
        end
        rst_n     = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", {31'd0, in_ready0}, 32'd1);
        chk("ready_after_rst1", {31'd0, in_ready1}, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("idle_ready", {31'd0, in_ready0}, 32'd1);
            chk("idle_busy", {31'd0, busy0}, 32'd0);
        end

        // Single word, MSB first.
        send(0, 8'hA5, 1'b0, hs);
        wait_to(hs + FB);
        chk("busy_last_bit", {31'd0, busy0}, 32'd1);
        chk("ready_last_bit", {31'd0, in_ready0}, 32'd0);
        wait_to(hs + FB + 1);
        chk("gap_busy", {31'd0, busy0}, 32'd0);
        chk("gap_ready", {31'd0, in_ready0}, 32'd1);
        chk("gap_valid", {31'd0, d_valid0}, 32'd0);

        // Single word, LSB first.
        send(1, 8'h01, 1'b0, hs);
        wait_to(hs + FB + 2);

        // Back-to-back with in_data churning mid-frame.
        send(0, 8'hFF, 1'b1, h1);
        repeat (4) begin
            @(posedge clk);
            #1;
            in_data0 = 8'($urandom);
        end
        send(0, 8'h00, 1'b0, h2);
        chk("b2b_spacing", h2 - h1, FB + 2);
        wait_to(h2 + FB + 2);

        // Reset after the 3rd bit of 8'hC3 aborts the frame.
        send(0, 8'hC3, 1'b0, hs);
        wait_to(hs + 3);
        rst_n = 1'b0;
        while (exp_q0.size() > 0 && exp_q0[$].cyc > hs + 3) void'(exp_q0.pop_back());
        @(posedge clk);
        #1;
        chk("abort_d", {31'd0, d0}, 32'd0);
        chk("abort_valid", {31'd0, d_valid0}, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        chk("abort_ready", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(0, 8'h3C, 1'b0, hs);
        wait_to(hs + FB + 2);

        // Parity-sensitive words (parity bit present only with the macro defined).
        send(0, 8'h07, 1'b0, hs);
        wait_to(hs + FB + 2);
        send(0, 8'h03, 1'b0, hs);
        wait_to(hs + FB + 3);

        chk("drain0", exp_q0.size(), 0);
        chk("drain1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
